// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state type and constant helpers for operand_mux_arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tag_pipe.sv
// tag_pipe: fixed-depth shift pipeline carrying a valid bit and a requester tag.
module tag_pipe #(
    parameter int Depth = 4,
    parameter int TagW  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    input  logic [TagW-1:0] i_tag,
    output logic            o_valid,
    output logic [TagW-1:0] o_tag
);
    logic [Depth-1:0] r_valid;
    logic [TagW-1:0]  r_tag [Depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < Depth; i++) r_tag[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_tag[0]   <= i_tag;
            for (int i = 1; i < Depth; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

    assign o_valid = r_valid[Depth-1];
    assign o_tag   = r_tag[Depth-1];

endmodule

// File: rtl/operand_mux_arbiter.sv
// operand_mux_arbiter: round-robin issue onto a shared pipelined operator with done tracking.
// Define ARB_DONE_REG_EN to register done one extra stage (latency OpLatency+1).
module operand_mux_arbiter
    import arb_pkg::*;
#(
    parameter int NumReq    = 4,
    parameter int OpLatency = 4,
    parameter int SelWidth  = clog2(NumReq)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NumReq-1:0]   req,
    output logic [NumReq-1:0]   grant,
    output logic [SelWidth-1:0] sel,
    output logic                op_valid,
    output logic [NumReq-1:0]   done,
    input  logic                drain,
    output logic                drained
);
`ifdef ARB_DONE_REG_EN
    localparam int MaxFlight = OpLatency + 1;
`else
    localparam int MaxFlight = OpLatency;
`endif
    localparam int CntW = clog2(MaxFlight + 1);
    localparam logic [NumReq-1:0] One = {{(NumReq-1){1'b0}}, 1'b1};

    state_t              r_state, w_state_nxt;
    logic [SelWidth-1:0] r_ptr, r_sel, w_idx, w_cand;
    logic [CntW-1:0]     r_cnt, w_cnt_nxt;
    logic                w_found, w_issue_en, w_pipe_valid;
    logic [SelWidth-1:0] w_pipe_tag;
    logic [NumReq-1:0]   w_done;

    // First requester strictly after the last grantee, wrapping around
    always_comb begin
        w_found = 1'b0;
        w_idx   = r_ptr;
        w_cand  = r_ptr;
        for (int i = 1; i <= NumReq; i++) begin
            w_cand = SelWidth'((int'(r_ptr) + i) % NumReq);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_idx   = w_cand;
            end
        end
    end

    assign w_issue_en = rst_n && (r_state != DRAIN) && !drain;
    assign grant      = (w_issue_en && w_found) ? One << w_idx : '0;
    assign op_valid   = |grant;
    assign sel        = op_valid ? w_idx : r_sel;
    assign drained    = (r_state == IDLE) && (r_cnt == '0);

    tag_pipe #(.Depth(OpLatency), .TagW(SelWidth)) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (op_valid),
        .i_tag   (w_idx),
        .o_valid (w_pipe_valid),
        .o_tag   (w_pipe_tag)
    );

    assign w_done = w_pipe_valid ? One << w_pipe_tag : '0;

`ifdef ARB_DONE_REG_EN
    logic [NumReq-1:0] r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= '0;
        else        r_done <= w_done;
    end

    assign done = r_done;
`else
    assign done = w_done;
`endif

    assign w_cnt_nxt = r_cnt + CntW'(op_valid) - CntW'(|done);

    // Idle checks use the post-update count so drained rises right after the last done
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = (|req && !drain) ? RUN : IDLE;
            RUN:     w_state_nxt = drain ? DRAIN : ((req == '0 && w_cnt_nxt == '0) ? IDLE : RUN);
            DRAIN:   w_state_nxt = (w_cnt_nxt == '0 && !drain) ? IDLE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= SelWidth'(NumReq - 1);
            r_sel   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (op_valid) begin
                r_ptr <= w_idx;
                r_sel <= w_idx;
            end
        end
    end

endmodule

// File: tb/tb_operand_mux_arbiter.sv
// tb_operand_mux_arbiter: vector tables, directed corner sequences and a random run against a queue-based model.
module tb_operand_mux_arbiter;
    localparam int N = 4;
    localparam int L = 4;
`ifdef ARB_DONE_REG_EN
    localparam int LAT = L + 1;
`else
    localparam int LAT = L;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         drain = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] grant, done;
    logic [1:0]   sel;
    logic         op_valid, drained;

    operand_mux_arbiter #(.NumReq(N), .OpLatency(L), .SelWidth(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .grant    (grant),
        .sel      (sel),
        .op_valid (op_valid),
        .done     (done),
        .drain    (drain),
        .drained  (drained)
    );

    always #5 clk = ~clk;

    typedef struct { int t; int idx; } flight_t;
    typedef struct { logic [N-1:0] r; logic d; logic [N-1:0] g; logic [N-1:0] dn; } vec_t;

    int errors = 0;
    int checks = 0;
    flight_t q[$];
    int m_ptr = N - 1, m_state = 0, m_sel = 0, m_cyc = 0;
    logic [N-1:0] obs_grant, obs_done;
    logic obs_drained;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, m_cyc, act, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // One clock: drive after the edge, compare at negedge, advance the model at the next edge
    task automatic step(input logic [N-1:0] r, input logic d);
        int g, di;
        logic [N-1:0] eg, ed;
        req = r;
        drain = d;
        g  = (m_state != 2 && !d) ? pick(r) : -1;
        di = (q.size() > 0 && q[0].t == m_cyc) ? q[0].idx : -1;
        eg = (g >= 0) ? N'(1) << g : '0;
        ed = (di >= 0) ? N'(1) << di : '0;
        @(negedge clk);
        obs_grant = grant;
        obs_done = done;
        obs_drained = drained;
        chk("grant", grant, eg);
        chk("done", done, ed);
        chk("op_valid", op_valid, g >= 0);
        chk("sel", sel, (g >= 0) ? g : m_sel);
        chk("drained", drained, m_state == 0 && q.size() == 0);
        @(posedge clk);
        if (di >= 0) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back('{m_cyc + LAT, g});
            m_ptr = g;
            m_sel = g;
        end
        case (m_state)
            0: if (|r && !d) m_state = 1;
            1: if (d) m_state = 2; else if (r == 0 && q.size() == 0) m_state = 0;
            2: if (q.size() == 0 && !d) m_state = 0;
            default: m_state = 0;
        endcase
        m_cyc++;
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        req = r;
        drain = 1'b0;
        rst_n = 1'b0;
        #2;
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_op_valid", op_valid, 0);
        chk("rst_sel", sel, 0);
        chk("rst_drained", drained, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req = '0;
        q.delete();
        m_ptr = N - 1;
        m_state = 0;
        m_sel = 0;
        m_cyc++;
    endtask

    initial begin
        vec_t tv[13];
        vec_t tv2[4];
        int n_done, last_done, first_drained, dlen;

        for (int i = 0; i < 13; i++) begin
            tv[i].r  = (i < 8) ? '1 : '0;
            tv[i].d  = 1'b0;
            tv[i].g  = (i < 8) ? N'(1) << (i % 4) : '0;
            tv[i].dn = (i >= LAT && i - LAT < 8) ? N'(1) << ((i - LAT) % 4) : '0;
        end
        tv2[0] = '{4'b1111, 1'b0, 4'b0001, 4'b0000};
        tv2[1] = '{4'b0111, 1'b0, 4'b0010, 4'b0000};
        tv2[2] = '{4'b0111, 1'b0, 4'b0100, 4'b0000};
        tv2[3] = '{4'b0111, 1'b0, 4'b0001, 4'b0000};

        do_reset(4'b1111);
        for (int i = 0; i < 13; i++) begin
            step(tv[i].r, tv[i].d);
            chk("tv_grant", obs_grant, tv[i].g);
            chk("tv_done", obs_done, tv[i].dn);
        end

        do_reset(4'b0000);
        for (int i = 0; i < 4; i++) begin
            step(tv2[i].r, tv2[i].d);
            chk("drop_grant", obs_grant, tv2[i].g);
        end
        for (int i = 0; i < LAT + 2; i++) step('0, 1'b0);

        do_reset(4'b0100);
        for (int i = 0; i < 12; i++) begin
            step(4'b0100, 1'b0);
            chk("single_grant", obs_grant, 4'b0100);
            if (i >= LAT) chk("single_done", obs_done, 4'b0100);
        end
        for (int i = 0; i < LAT + 2; i++) step('0, 1'b0);

        do_reset(4'b0000);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0);
        step(4'b1111, 1'b1);
        chk("drain_nogrant", obs_grant, 0);
        n_done = (obs_done != 0) ? 1 : 0;
        last_done = (obs_done != 0) ? 0 : -1;
        first_drained = -1;
        for (int i = 1; i < 20 && first_drained < 0; i++) begin
            step('0, 1'b0);
            if (obs_done != 0) begin
                n_done++;
                last_done = i;
            end
            if (obs_drained) first_drained = i;
        end
        chk("drain_ndone", n_done, 3);
        chk("drain_drained_at", first_drained, last_done + 1);

        do_reset(4'b0000);
        step(4'b1111, 1'b0);
        step(4'b1111, 1'b0);
        do_reset(4'b1111);
        n_done = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            step('0, 1'b0);
            if (obs_done != 0) n_done++;
        end
        chk("rst_no_done", n_done, 0);
        step(4'b1111, 1'b0);
        chk("rst_first_grant", obs_grant, 4'b0001);

        dlen = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [N-1:0] r;
            if ($urandom_range(0, 299) == 0) do_reset(N'($urandom));
            if (dlen == 0 && $urandom_range(0, 40) == 0) dlen = $urandom_range(1, 8);
            r = ($urandom_range(0, 3) == 0) ? N'(1) << $urandom_range(0, N - 1) : N'($urandom);
            step(r, dlen > 0);
            if (dlen > 0) dlen--;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_mux_arbiter.md
OPERAND_MUX_ARBITER -- requirements
Module: operand_mux_arbiter

Interface
REQ-001 SHALL have parameter NumReq, default 4; number of requesters sharing one operator, legal range 2..11.
REQ-002 SHALL have parameter OpLatency, default 4; fixed pipeline depth of the shared operator in cycles, legal range 1..16.
REQ-003 SHALL have parameter SelWidth, default 2; width of the mux select, equal to ceil(log2(NumReq)).
REQ-004 SHALL have port clk, input, 1; the single clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1; reset, asynchronous, active-low.
REQ-006 SHALL have port req, input, NumReq; per-requester operation request, level, held until granted.
REQ-007 SHALL have port grant, output, NumReq; one-hot issue acknowledge, combinational from req and registered state.
REQ-008 SHALL have port sel, output, SelWidth; select driving the shared MUXn S input (index k selects input I(k+1)).
REQ-009 SHALL have port op_valid, output, 1; operands presented to the operator this cycle.
REQ-010 SHALL have port done, output, NumReq; one-hot pulse when the owner's result leaves the operator.
REQ-011 SHALL have port drain, input, 1; stop issuing and empty the pipeline.
REQ-012 SHALL have port drained, output, 1; high while in IDLE with zero operations in flight.

Function
REQ-013 SHALL grant at most one requester per cycle, round-robin starting from the index after the last grantee.
REQ-014 SHALL set op_valid = |grant and sel = index of the granted bit; sel SHALL hold its previous value when nothing is granted.
REQ-015 SHALL push the grantee index and a valid bit into an OpLatency-deep tag pipeline on each issue.
REQ-016 SHALL pulse done[k] exactly OpLatency cycles after the cycle grant[k] was high.
REQ-017 SHALL keep an in-flight count 0..OpLatency: increment on issue, decrement on done, unchanged on simultaneous issue and done.
REQ-018 SHALL implement states IDLE, RUN and DRAIN.
REQ-019 Transitions: IDLE->RUN when |req and !drain; RUN->DRAIN on drain; RUN->IDLE when req==0 and count==0; DRAIN->IDLE when count==0 and drain is low.
REQ-020 SHALL issue no grants in DRAIN, or in IDLE while drain is high.
REQ-021 In DRAIN, in-flight results SHALL still produce done pulses.
REQ-022 SHALL keep the round-robin pointer unchanged across DRAIN.
REQ-023 A requester that drops req before being granted SHALL forfeit its turn without an error.
REQ-024 With a single active requester, that requester SHALL be granted every cycle (back-to-back issue).

Reset
REQ-025 On rst_n low, state SHALL become IDLE, the round-robin pointer NumReq-1 (so index 0 wins first), in-flight count 0 and the tag pipeline cleared.
REQ-026 During reset, grant, done and op_valid SHALL be 0, sel SHALL be 0 and drained SHALL be 1.
REQ-027 Reset asserted mid-operation SHALL discard in-flight tags, with no done pulse after release.

Configuration
REQ-028 With ARB_DONE_REG_EN defined, done SHALL be registered one extra stage: latency OpLatency+1, count decremented on the registered pulse.
REQ-029 Without ARB_DONE_REG_EN, done SHALL be the tag pipeline output directly: latency OpLatency.

Structure
REQ-030 Package arb_pkg SHALL hold the state typedef (IDLE/RUN/DRAIN) and a clog2 constant function.
REQ-031 The tag pipeline SHALL be a sub-module tag_pipe, with parameters for depth and tag width, carrying valid and tag.

Verification
REQ-032 NumReq=4, OpLatency=4, req=4'b1111 held for 8 cycles -> grant sequence 0,1,2,3,0,1,2,3; done[0] first at cycle 4 after the first grant.
REQ-033 req=4'b0100 only -> grant[2] every cycle, sel=2, one done[2] per cycle from cycle 4; count saturates at 4.
REQ-034 drain raised with count=3 -> no grants; done pulses at the remaining 3 slots; drained=1 in the cycle after the last done.
REQ-035 rst_n pulled low for 1 cycle with 2 ops in flight -> no done pulses afterward; the first grant after release goes to index 0.
REQ-036 ARB_DONE_REG_EN defined, single issue on req[1] -> done[1] exactly 5 cycles after grant[1].
REQ-037 req[3] dropped before its turn while req[0..2] are held -> rotation 0,1,2,0 with no grant[3].
